// File: rtl/cdb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cdb_arbiter                                                |
// | Description : Common data bus arbiter. Each functional unit hands a      |
// |               finished result into a one-entry holding slot; a round-    |
// |               robin scheduler broadcasts one held result per cycle on a  |
// |               registered CDB output. A held result is broadcast on the   |
// |               edge after the one that loaded it.                         |
// | Options     : CDB_ARB_PERF_EN adds per-source stall counters and a       |
// |               broadcast counter as extra output ports.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cdb_arbiter #(
   parameter int N_REQ  = 3,
   parameter int ROB_W  = 3,
   parameter int DATA_W = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*ROB_W-1:0]    req_rob_id,
   input  logic [N_REQ*DATA_W-1:0]   req_value,
   input  logic [N_REQ-1:0]          req_branch,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      cdb_valid,
   output logic [ROB_W-1:0]          cdb_rob_id,
   output logic [DATA_W-1:0]         cdb_value,
   output logic                      cdb_branch,
`ifdef CDB_ARB_PERF_EN
   output logic [$clog2(N_REQ)-1:0]  cdb_src,
   output logic [N_REQ*16-1:0]       perf_stall_cnt,
   output logic [31:0]               perf_bcast_cnt
`else
   output logic [$clog2(N_REQ)-1:0]  cdb_src
`endif
);

   localparam int                 c_src_w = $clog2(N_REQ);
   localparam logic [c_src_w-1:0] c_last  = c_src_w'(N_REQ - 1);
   localparam logic [c_src_w:0]   c_n_req = (c_src_w + 1)'(N_REQ);

   // Holding slots, one per source
   logic [N_REQ-1:0]   r_slot_valid;
   logic [ROB_W-1:0]   r_slot_rob_id [N_REQ];
   logic [DATA_W-1:0]  r_slot_value  [N_REQ];
   logic [N_REQ-1:0]   r_slot_branch;

   // Scheduler state and registered broadcast
   logic [c_src_w-1:0] r_rr_ptr;
   logic               r_cdb_valid;
   logic [ROB_W-1:0]   r_cdb_rob_id;
   logic [DATA_W-1:0]  r_cdb_value;
   logic               r_cdb_branch;
   logic [c_src_w-1:0] r_cdb_src;

   // Combinational arbitration results
   logic               w_any;
   logic [c_src_w-1:0] w_winner;
   logic [c_src_w:0]   w_scan;
   logic [N_REQ-1:0]   w_grant;
   logic [c_src_w-1:0] w_next_ptr;
   logic [N_REQ-1:0]   w_ready;
   logic [N_REQ-1:0]   w_accept;

   // Round-robin scan of held slots starting at rr_ptr; the index wraps by
   // explicit compare so non-power-of-two source counts work.
   always_comb begin
      w_any    = 1'b0;
      w_winner = '0;
      w_scan   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_scan = {1'b0, r_rr_ptr} + (c_src_w + 1)'(k);
         if (w_scan >= c_n_req) begin
            w_scan = w_scan - c_n_req;
         end
         if (!w_any && r_slot_valid[w_scan[c_src_w-1:0]]) begin
            w_any    = 1'b1;
            w_winner = w_scan[c_src_w-1:0];
         end
      end
   end

   // One-hot grant to the scan winner, zero when nothing is held
   always_comb begin
      w_grant = '0;
      if (w_any) begin
         w_grant[w_winner] = 1'b1;
      end
   end

   assign w_next_ptr = (w_winner == c_last) ? '0 : w_winner + 1'b1;

   // A slot being granted this cycle can take a new result at the same edge
   assign w_ready  = {N_REQ{rst & ~flush}} & (~r_slot_valid | w_grant);
   assign w_accept = req_valid & w_ready;

   // Slot occupancy, pointer and CDB broadcast register
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_slot_valid <= '0;
         r_rr_ptr     <= '0;
         r_cdb_valid  <= 1'b0;
         r_cdb_rob_id <= '0;
         r_cdb_value  <= '0;
         r_cdb_branch <= 1'b0;
         r_cdb_src    <= '0;
      end else if (flush) begin
         r_slot_valid <= '0;
         r_rr_ptr     <= '0;
         r_cdb_valid  <= 1'b0;
      end else begin
         r_slot_valid <= w_accept | (r_slot_valid & ~w_grant);
         r_cdb_valid  <= w_any;
         if (w_any) begin
            r_rr_ptr     <= w_next_ptr;
            r_cdb_rob_id <= r_slot_rob_id[w_winner];
            r_cdb_value  <= r_slot_value[w_winner];
            r_cdb_branch <= r_slot_branch[w_winner];
            r_cdb_src    <= w_winner;
         end
      end
   end

   // Slot payload capture on accept; payload is meaningless while invalid
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_REQ; i++) begin
         if (w_accept[i]) begin
            r_slot_rob_id[i] <= req_rob_id[i*ROB_W +: ROB_W];
            r_slot_value[i]  <= req_value[i*DATA_W +: DATA_W];
            r_slot_branch[i] <= req_branch[i];
         end
      end
   end

   assign req_ready  = w_ready;
   assign cdb_valid  = r_cdb_valid;
   assign cdb_rob_id = r_cdb_rob_id;
   assign cdb_value  = r_cdb_value;
   assign cdb_branch = r_cdb_branch;
   assign cdb_src    = r_cdb_src;

`ifdef CDB_ARB_PERF_EN
   logic [31:0] r_bcast_cnt;

   for (genvar i = 0; i < N_REQ; i++) begin : g_stall
      logic [15:0] r_stall_cnt;

      // Saturating count of cycles this source offers a result but is refused
      always_ff @(posedge clk) begin
         if (!rst) begin
            r_stall_cnt <= '0;
         end else if (req_valid[i] && !w_ready[i] && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
      end

      assign perf_stall_cnt[i*16 +: 16] = r_stall_cnt;
   end

   // Wrapping count of cycles with a valid broadcast on the bus
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_bcast_cnt <= '0;
      end else if (r_cdb_valid) begin
         r_bcast_cnt <= r_bcast_cnt + 32'd1;
      end
   end

   assign perf_bcast_cnt = r_bcast_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cdb_arbiter                                             |
// | Description : Directed self-checking bench for cdb_arbiter (3 sources).  |
// |               Results load into a slot at one edge and appear on the CDB |
// |               after the following edge.                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cdb_arbiter;

   logic        clk;
   logic        rst;
   logic        flush;
   logic [2:0]  req_valid;
   logic [8:0]  req_rob_id;
   logic [95:0] req_value;
   logic [2:0]  req_branch;
   logic [2:0]  req_ready;
   logic        cdb_valid;
   logic [2:0]  cdb_rob_id;
   logic [31:0] cdb_value;
   logic        cdb_branch;
   logic [1:0]  cdb_src;
`ifdef CDB_ARB_PERF_EN
   logic [47:0] perf_stall_cnt;
   logic [31:0] perf_bcast_cnt;
`endif

   int n_checks = 0;
   int n_err    = 0;

   cdb_arbiter #(
      .N_REQ  (3),
      .ROB_W  (3),
      .DATA_W (32)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .req_valid      (req_valid),
      .req_rob_id     (req_rob_id),
      .req_value      (req_value),
      .req_branch     (req_branch),
      .req_ready      (req_ready),
      .cdb_valid      (cdb_valid),
      .cdb_rob_id     (cdb_rob_id),
      .cdb_value      (cdb_value),
      .cdb_branch     (cdb_branch),
`ifdef CDB_ARB_PERF_EN
      .cdb_src        (cdb_src),
      .perf_stall_cnt (perf_stall_cnt),
      .perf_bcast_cnt (perf_bcast_cnt)
`else
      .cdb_src        (cdb_src)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [2:0] rob, input logic [31:0] val, input logic br);
      req_rob_id[i*3 +: 3]  = rob;
      req_value[i*32 +: 32] = val;
      req_branch[i]         = br;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst        = 1'b0;
      flush      = 1'b0;
      req_valid  = '0;
      req_rob_id = '0;
      req_value  = '0;
      req_branch = '0;

      // Reset held for two edges
      tick();
      tick();
      chk("rst_valid",  cdb_valid,  0);
      chk("rst_src",    cdb_src,    0);
      chk("rst_rob",    cdb_rob_id, 0);
      chk("rst_value",  cdb_value,  0);
      chk("rst_branch", cdb_branch, 0);
      chk("rst_ready",  req_ready,  3'b000);

      // Idle after release
      rst = 1'b1;
      #1;
      chk("idle_ready", req_ready, 3'b111);
      repeat (2) begin
         tick();
         chk("idle_valid", cdb_valid, 0);
         chk("idle_src",   cdb_src,   0);
         chk("idle_ready", req_ready, 3'b111);
      end

      // Single request from source 1
      set_req(1, 3'd5, 32'hDEADBEEF, 1'b1);
      req_valid = 3'b010;
      #1;
      chk("single_ready_in", req_ready, 3'b111);
      tick();
      req_valid = 3'b000;
      #1;
      chk("single_pending", cdb_valid, 0);
      chk("single_ready_held", req_ready, 3'b111);
      tick();
      chk("single_valid",  cdb_valid,  1);
      chk("single_rob",    cdb_rob_id, 5);
      chk("single_value",  cdb_value,  32'hDEADBEEF);
      chk("single_branch", cdb_branch, 1);
      chk("single_src",    cdb_src,    1);
      tick();
      chk("single_after_valid", cdb_valid, 0);
      chk("single_hold_src",    cdb_src,   1);
      chk("single_hold_value",  cdb_value, 32'hDEADBEEF);

      // Flush with nothing held brings rr_ptr back to 0
      flush = 1'b1;
      #1;
      chk("flush0_ready", req_ready, 3'b000);
      tick();
      flush = 1'b0;
      chk("flush0_valid", cdb_valid, 0);

      // Contention: all three sources valid every cycle
      set_req(0, 3'd1, 32'h100, 1'b0);
      set_req(1, 3'd2, 32'h200, 1'b1);
      set_req(2, 3'd3, 32'h300, 1'b0);
      req_valid = 3'b111;
      #1;
      chk("cont_ready_first", req_ready, 3'b111);
      tick();
      chk("cont_ready_0", req_ready, 3'b001);
      chk("cont_valid_0", cdb_valid, 0);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("cont_valid", cdb_valid,  1);
         chk("cont_src",   cdb_src,    k % 3);
         chk("cont_rob",   cdb_rob_id, (k % 3) + 1);
         chk("cont_ready", req_ready,  3'b001 << ((k + 1) % 3));
      end
      // Drain the three refilled slots in round-robin order
      req_valid = 3'b000;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("drain_valid", cdb_valid, 1);
         chk("drain_src",   cdb_src,   k);
      end
      tick();
      chk("drain_empty", cdb_valid, 0);

      // Back-to-back from source 0, others idle
      for (int k = 0; k < 4; k++) begin
         set_req(0, 3'(k + 1), 32'h11 * (k + 1), 1'b0);
         req_valid = 3'b001;
         #1;
         chk("b2b_ready", req_ready, 3'b111);
         tick();
         chk("b2b_valid", cdb_valid, (k > 0) ? 1 : 0);
         if (k > 0) begin
            chk("b2b_rob", cdb_rob_id, k);
         end
      end
      req_valid = 3'b000;
      tick();
      chk("b2b_last_valid", cdb_valid,  1);
      chk("b2b_last_rob",   cdb_rob_id, 4);
      chk("b2b_last_value", cdb_value,  32'h44);
      tick();
      chk("b2b_end", cdb_valid, 0);

      // Flush while slots 0 and 2 are held (rr_ptr is 1 here)
      set_req(0, 3'd6, 32'hAAAA0006, 1'b1);
      set_req(2, 3'd7, 32'hBBBB0007, 1'b0);
      req_valid = 3'b101;
      tick();
      req_valid = 3'b000;
      flush     = 1'b1;
      #1;
      chk("flush_ready", req_ready, 3'b000);
      tick();
      flush = 1'b0;
      repeat (3) begin
         chk("flush_no_bcast", cdb_valid, 0);
         tick();
      end
      // Sources 0 and 1 together: source 0 first only if rr_ptr is 0
      set_req(0, 3'd1, 32'h0101, 1'b0);
      set_req(1, 3'd2, 32'h0202, 1'b0);
      req_valid = 3'b011;
      tick();
      req_valid = 3'b000;
      tick();
      chk("post_flush_src0", cdb_src,    0);
      chk("post_flush_rob0", cdb_rob_id, 1);
      tick();
      chk("post_flush_src1", cdb_src,    1);
      tick();
      chk("post_flush_idle", cdb_valid, 0);

      // Reset while a result is held drops it
      set_req(1, 3'd3, 32'h0303, 1'b0);
      req_valid = 3'b010;
      tick();
      req_valid = 3'b000;
      rst       = 1'b0;
      tick();
      rst = 1'b1;
      chk("rst_mid_valid", cdb_valid, 0);
      tick();
      chk("rst_mid_dropped", cdb_valid, 0);

      // Wrap: grant source 2, pointer wraps to 0
      set_req(2, 3'd3, 32'h3333, 1'b1);
      req_valid = 3'b100;
      tick();
      req_valid = 3'b000;
      tick();
      chk("wrap_src2",   cdb_src,    2);
      chk("wrap_branch", cdb_branch, 1);
      set_req(0, 3'd1, 32'h1111, 1'b0);
      set_req(2, 3'd2, 32'h2222, 1'b0);
      req_valid = 3'b101;
      #1;
      chk("wrap_ready_in", req_ready, 3'b111);
      tick();
      // Source 2 offers another result while its slot is still held
      req_valid = 3'b100;
      #1;
      chk("wrap_ready_stall", req_ready, 3'b011);
      tick();
      chk("wrap_win_src", cdb_src,    0);
      chk("wrap_win_rob", cdb_rob_id, 1);
`ifdef CDB_ARB_PERF_EN
      chk("perf_stall2", perf_stall_cnt[32 +: 16], 1);
      chk("perf_stall0", perf_stall_cnt[0 +: 16],  0);
      chk("perf_bcast1", perf_bcast_cnt, 1);
`endif
      req_valid = 3'b000;
      tick();
      chk("wrap_next_src", cdb_src,    2);
      chk("wrap_next_rob", cdb_rob_id, 2);
`ifdef CDB_ARB_PERF_EN
      chk("perf_stall2_hold", perf_stall_cnt[32 +: 16], 1);
      chk("perf_bcast2", perf_bcast_cnt, 2);
`endif
      tick();
      chk("wrap_end", cdb_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire
